xcfi_rvfi_trace_buffer: RTL

- Upstream producer of the RVFI trace consumed by the per-instruction formal spec models, such as the xc.sha3.* and other XCFI instruction checkers.
- Captures each instruction's static and operand information at dispatch, then holds it in an in-order buffer while the instruction is in flight.
- Merges the held record with writeback/commit data at retirement.
- Emits one registered rvfi_* record per retired instruction with a monotonically increasing order number.

---
 rtl/xcfi_rvfi_trace_buffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/xcfi_rvfi_trace_buffer.sv
// xcfi_rvfi_trace_buffer
// Holds dispatch-time operand data for in-flight instructions in an in-order
// circular buffer and merges each record with retirement data. The result is
// one registered rvfi_* trace record per retired instruction.
module xcfi_rvfi_trace_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cap_valid,
    input  logic [31:0] cap_insn,
    input  logic [31:0] cap_pc,
    input  logic [31:0] cap_rs1_rdata,
    input  logic [31:0] cap_rs2_rdata,
    input  logic [31:0] cap_rs3_rdata,
    output logic        cap_ready,
    input  logic        ret_valid,
    input  logic        ret_trap,
    input  logic [4:0]  ret_rd_addr,
    input  logic [31:0] ret_rd_wdata,
    input  logic        ret_rd_wide,
    input  logic [31:0] ret_rd_wdatahi,
    input  logic [31:0] ret_pc_wdata,
    input  logic        flush,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic        rvfi_trap,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [4:0]  rvfi_rs3_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [31:0] rvfi_rs3_rdata,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic        rvfi_rd_wide,
    output logic [31:0] rvfi_rd_wdatahi,
    output logic        trace_err
);

    // Pointers carry one extra wrap bit so full and empty are distinct.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    // Record storage, indexed by the low pointer bits.
    logic [31:0] mem_insn_r [DEPTH];
    logic [31:0] mem_pc_r   [DEPTH];
    logic [31:0] mem_rs1_r  [DEPTH];
    logic [31:0] mem_rs2_r  [DEPTH];
    logic [31:0] mem_rs3_r  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             err_s;
    logic [63:0]      order_cnt_r;

    logic        rvfi_valid_r;
    logic [63:0] rvfi_order_r;
    logic [31:0] rvfi_insn_r;
    logic        rvfi_trap_r;
    logic [31:0] rvfi_pc_rdata_r;
    logic [31:0] rvfi_pc_wdata_r;
    logic [31:0] rvfi_rs1_rdata_r;
    logic [31:0] rvfi_rs2_rdata_r;
    logic [31:0] rvfi_rs3_rdata_r;
    logic [4:0]  rvfi_rd_addr_r;
    logic [31:0] rvfi_rd_wdata_r;
    logic        rvfi_rd_wide_r;
    logic [31:0] rvfi_rd_wdatahi_r;
    logic        trace_err_r;

    assign wr_idx_s = wr_ptr_r[IDX_W-1:0];
    assign rd_idx_s = rd_ptr_r[IDX_W-1:0];
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign full_s   = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                      (wr_idx_s == rd_idx_s);

    // A full buffer still accepts a capture when the head retires the same cycle.
    assign pop_s    = ret_valid && !empty_s;
    assign push_s   = cap_valid && (!full_s || ret_valid) && !flush;
    assign err_s    = (ret_valid && empty_s) ||
                      (cap_valid && full_s && !ret_valid && !flush);

    assign cap_ready = !full_s;

    // Next-pointer selection; flush drops every record still held after the pop.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (flush) begin
            rd_ptr_nxt_s = wr_ptr_r;
        end else if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer, order counter and sticky error state.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            order_cnt_r <= 64'd0;
            trace_err_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            if (pop_s) begin
                order_cnt_r <= order_cnt_r + 64'd1;
            end
            if (err_s) begin
                trace_err_r <= 1'b1;
            end
        end
    end

    // Record write on capture; contents are meaningless until the pointers cover them.
    always_ff @(posedge g_clk) begin
        if (push_s) begin
            mem_insn_r[wr_idx_s] <= cap_insn;
            mem_pc_r[wr_idx_s]   <= cap_pc;
            mem_rs1_r[wr_idx_s]  <= cap_rs1_rdata;
            mem_rs2_r[wr_idx_s]  <= cap_rs2_rdata;
            mem_rs3_r[wr_idx_s]  <= cap_rs3_rdata;
        end
    end

    // Merge the head record with retirement data into the registered trace port.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rvfi_valid_r      <= 1'b0;
            rvfi_order_r      <= 64'd0;
            rvfi_insn_r       <= 32'd0;
            rvfi_trap_r       <= 1'b0;
            rvfi_pc_rdata_r   <= 32'd0;
            rvfi_pc_wdata_r   <= 32'd0;
            rvfi_rs1_rdata_r  <= 32'd0;
            rvfi_rs2_rdata_r  <= 32'd0;
            rvfi_rs3_rdata_r  <= 32'd0;
            rvfi_rd_addr_r    <= 5'd0;
            rvfi_rd_wdata_r   <= 32'd0;
            rvfi_rd_wide_r    <= 1'b0;
            rvfi_rd_wdatahi_r <= 32'd0;
        end else begin
            rvfi_valid_r <= pop_s;
            if (pop_s) begin
                rvfi_order_r      <= order_cnt_r;
                rvfi_insn_r       <= mem_insn_r[rd_idx_s];
                rvfi_pc_rdata_r   <= mem_pc_r[rd_idx_s];
                rvfi_rs1_rdata_r  <= mem_rs1_r[rd_idx_s];
                rvfi_rs2_rdata_r  <= mem_rs2_r[rd_idx_s];
                rvfi_rs3_rdata_r  <= mem_rs3_r[rd_idx_s];
                rvfi_trap_r       <= ret_trap;
                rvfi_pc_wdata_r   <= ret_pc_wdata;
                rvfi_rd_addr_r    <= ret_trap ? 5'd0 : ret_rd_addr;
                rvfi_rd_wdata_r   <= (ret_trap || (ret_rd_addr == 5'd0)) ? 32'd0 : ret_rd_wdata;
                rvfi_rd_wide_r    <= ret_rd_wide;
                rvfi_rd_wdatahi_r <= ret_rd_wide ? ret_rd_wdatahi : 32'd0;
            end
        end
    end

    assign rvfi_valid      = rvfi_valid_r;
    assign rvfi_order      = rvfi_order_r;
    assign rvfi_insn       = rvfi_insn_r;
    assign rvfi_trap       = rvfi_trap_r;
    assign rvfi_pc_rdata   = rvfi_pc_rdata_r;
    assign rvfi_pc_wdata   = rvfi_pc_wdata_r;
    assign rvfi_rs1_addr   = rvfi_insn_r[19:15];
    assign rvfi_rs2_addr   = rvfi_insn_r[24:20];
    assign rvfi_rs3_addr   = rvfi_insn_r[31:27];
    assign rvfi_rs1_rdata  = rvfi_rs1_rdata_r;
    assign rvfi_rs2_rdata  = rvfi_rs2_rdata_r;
    assign rvfi_rs3_rdata  = rvfi_rs3_rdata_r;
    assign rvfi_rd_addr    = rvfi_rd_addr_r;
    assign rvfi_rd_wdata   = rvfi_rd_wdata_r;
    assign rvfi_rd_wide    = rvfi_rd_wide_r;
    assign rvfi_rd_wdatahi = rvfi_rd_wdatahi_r;
    assign trace_err       = trace_err_r;

endmodule
